raptor_ecc_codec: RTL

//  Parametrised systematic SEC codec, successor of the fixed 8-bit checkerboard encoder. Encodes DATA_WIDTH

---
 rtl/raptor_ecc_pkg.sv | 36 +++
 rtl/raptor_ecc_syndrome.sv | 26 ++
 rtl/raptor_ecc_codec.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/raptor_ecc_pkg.sv
// rtl/raptor_ecc_pkg.sv - shared types and constant helpers for the raptor SEC codec
package raptor_ecc_pkg;

  // Request opcode carried on op
  localparam logic OP_ENCODE = 1'b0;
  localparam logic OP_DECODE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYND,
    ST_SCAN,
    ST_DONE
  } state_t;

  // H-matrix column of data bit j: the j-th integer >= 3 that is not a power of two.
  // Columns never exceed 255 for the supported data widths, which bounds the search.
  function automatic int col(input int j);
    int result;
    int k;
    result = 0;
    k = 0;
    for (int v = 3; v < 256; v++) begin
      if (result == 0 && (v & (v - 1)) != 0) begin
        if (k == j) result = v;
        k++;
      end
    end
    return result;
  endfunction

  // Width of an index into a codeword of cw bits
  function automatic int pos_w(input int cw);
    return (cw <= 1) ? 1 : $clog2(cw);
  endfunction

endpackage

// File: rtl/raptor_ecc_syndrome.sv
// rtl/raptor_ecc_syndrome.sv - combinational parity generator shared by encode and syndrome paths
module raptor_ecc_syndrome
  import raptor_ecc_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [PARITY_WIDTH-1:0] parity
);

  logic [PARITY_WIDTH-1:0] col_tab [DATA_WIDTH];

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_col
    assign col_tab[g] = PARITY_WIDTH'(col(g));
  end

  // Parity is the XOR of the H columns of every set data bit
  always_comb begin
    parity = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      if (data[j]) parity = parity ^ col_tab[j];
    end
  end

endmodule

// File: rtl/raptor_ecc_codec.sv
// rtl/raptor_ecc_codec.sv - valid/ready SEC encoder/decoder with scanned syndrome lookup
module raptor_ecc_codec
  import raptor_ecc_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_WIDTH = 4,
  parameter int SCAN_LANES   = 1,
  localparam int CW_WIDTH    = DATA_WIDTH + PARITY_WIDTH,
  localparam int POS_W       = pos_w(CW_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [CW_WIDTH-1:0]     codeword_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CW_WIDTH-1:0]     codeword_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    error_detected,
  output logic                    error_corrected,
  output logic [POS_W-1:0]        error_pos,
  output logic [PARITY_WIDTH-1:0] syndrome_out
);

  state_t                  state;
  logic [CW_WIDTH-1:0]     cw_reg;
  logic [PARITY_WIDTH-1:0] syn_reg;
  logic [POS_W-1:0]        scan_j;

  logic [DATA_WIDTH-1:0]   gen_data;
  logic [PARITY_WIDTH-1:0] gen_parity;
  logic [PARITY_WIDTH-1:0] syn_now;
  logic [PARITY_WIDTH-1:0] col_tab [DATA_WIDTH];

  logic p2_hit;
  int   p2_idx;
  logic scan_hit;
  int   scan_idx;
  int   j_int;
  logic scan_last;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_col
    assign col_tab[g] = PARITY_WIDTH'(col(g));
  end

  // In IDLE the generator encodes the live payload; afterwards it re-derives parity of the captured word
  assign gen_data = (state == ST_IDLE) ? data_in : cw_reg[DATA_WIDTH-1:0];
  assign syn_now  = gen_parity ^ cw_reg[CW_WIDTH-1:DATA_WIDTH];
  assign j_int    = int'(scan_j);

  raptor_ecc_syndrome #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PARITY_WIDTH(PARITY_WIDTH)
  ) u_syndrome (
    .data  (gen_data),
    .parity(gen_parity)
  );

  // A single-bit syndrome points straight at a parity bit
  always_comb begin
    p2_hit = 1'b0;
    p2_idx = 0;
    for (int i = 0; i < PARITY_WIDTH; i++) begin
      if (syn_now == (PARITY_WIDTH'(1) << i)) begin
        p2_hit = 1'b1;
        p2_idx = i;
      end
    end
  end

  // Compare this cycle's window of data columns; the lowest matching column wins
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = 0;
    for (int c = DATA_WIDTH - 1; c >= 0; c--) begin
      if (c >= j_int && c < j_int + SCAN_LANES && col_tab[c] == syn_reg) begin
        scan_hit = 1'b1;
        scan_idx = c;
      end
    end
    scan_last = (j_int + SCAN_LANES >= DATA_WIDTH);
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cw_reg          <= '0;
      syn_reg         <= '0;
      scan_j          <= '0;
      in_ready        <= 1'b0;
      out_valid       <= 1'b0;
      codeword_out    <= '0;
      data_out        <= '0;
      error_detected  <= 1'b0;
      error_corrected <= 1'b0;
      error_pos       <= '0;
      syndrome_out    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (op == OP_DECODE) begin
              cw_reg <= codeword_in;
              state  <= ST_SYND;
            end else begin
              codeword_out    <= {gen_parity, data_in};
              data_out        <= data_in;
              error_detected  <= 1'b0;
              error_corrected <= 1'b0;
              error_pos       <= '0;
              syndrome_out    <= '0;
              out_valid       <= 1'b1;
              state           <= ST_DONE;
            end
          end
        end
        ST_SYND: begin
          syn_reg         <= syn_now;
          syndrome_out    <= syn_now;
          error_detected  <= 1'b0;
          error_corrected <= 1'b0;
          error_pos       <= '0;
          if (syn_now == '0) begin
            codeword_out <= cw_reg;
            data_out     <= cw_reg[DATA_WIDTH-1:0];
            out_valid    <= 1'b1;
            state        <= ST_DONE;
          end else if (p2_hit) begin
            codeword_out    <= cw_reg ^ (CW_WIDTH'(1) << (DATA_WIDTH + p2_idx));
            data_out        <= cw_reg[DATA_WIDTH-1:0];
            error_corrected <= 1'b1;
            error_pos       <= POS_W'(DATA_WIDTH + p2_idx);
            out_valid       <= 1'b1;
            state           <= ST_DONE;
          end else begin
            scan_j <= '0;
            state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_hit) begin
            codeword_out    <= cw_reg ^ (CW_WIDTH'(1) << scan_idx);
            data_out        <= cw_reg[DATA_WIDTH-1:0] ^ (DATA_WIDTH'(1) << scan_idx);
            error_corrected <= 1'b1;
            error_pos       <= POS_W'(scan_idx);
            out_valid       <= 1'b1;
            state           <= ST_DONE;
          end else if (scan_last) begin
            codeword_out   <= cw_reg;
            data_out       <= cw_reg[DATA_WIDTH-1:0];
            error_detected <= 1'b1;
            out_valid      <= 1'b1;
            state          <= ST_DONE;
          end else begin
            scan_j <= scan_j + POS_W'(SCAN_LANES);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
